// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues word fetches over a req/ack handshake,
// buffers {word, PC} pairs in a FIFO for decode, and flushes/restarts on Redirect.
// Optional `IFQ_ALIGN_CHECK_EN`: misaligned StartPC/RedirectPC raises a sticky AlignFault and stops fetching.
//
// Handshakes:
//   Memory: MemReq rises with MemAddr and both hold until the cycle MemAck=1;
//   at most one request is outstanding, and MemAck while MemReq=0 is ignored.
//   Decode: an entry leaves the queue on a cycle with InstrValid && InstrReady
//   (a Redirect in that cycle wins and no entry is delivered).
module ifetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [63:0]       StartPC,
  input  logic              Redirect,
  input  logic [63:0]       RedirectPC,
  output logic              MemReq,
  output logic [63:0]       MemAddr,
  input  logic              MemAck,
  input  logic [31:0]       MemData,
  output logic              InstrValid,
  output logic [31:0]       Instruction,
  output logic [63:0]       InstrPC,
  input  logic              InstrReady,
  output logic [CNT_W-1:0]  QueueCount,
  output logic              AlignFault,
  output logic [1:0]        DbgState
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic               mem_req_q, mem_req_d;
  logic [63:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               started_q;
  logic [31:0]        data_q [DEPTH];
  logic [63:0]        pc_q   [DEPTH];

  logic               ack;
  logic               pop;
  logic               push;
  logic               fault;
  logic [CNT_W-1:0]   cnt_after_push;

  assign ack = mem_req_q && MemAck;
  assign pop = (count_q != '0) && InstrReady && !Redirect;
  assign cnt_after_push = count_q + ONE_C - {{(CNT_W-1){1'b0}}, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    case (state_q)
      ST_RUN: begin
        // started_q delays the first issue by one edge after reset release.
        if (!Redirect && started_q && !fault && (count_q < DEPTH_C)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (Redirect) begin
          if (ack) begin
            mem_req_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_DRAIN;
          end
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_d = mem_addr_q + 64'd4;
          if (cnt_after_push < DEPTH_C) begin
            mem_addr_d = mem_addr_q + 64'd4;
          end else begin
            mem_req_d  = 1'b0;
            state_d    = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_RUN;
      end
    endcase
    if (Redirect) begin
      fetch_pc_d = {RedirectPC[63:2], 2'b00};
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= {StartPC[63:2], 2'b00};
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      started_q  <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset || Redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr_q] <= MemData;
      pc_q[wr_ptr_q]   <= mem_addr_q;
    end
  end

`ifdef IFQ_ALIGN_CHECK_EN
  logic align_fault_q;
  logic start_mis_q;

  // StartPC alignment is judged on the value present during reset, raised on release.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      align_fault_q <= 1'b0;
      start_mis_q   <= |StartPC[1:0];
    end else if ((!started_q && start_mis_q) || (Redirect && (|RedirectPC[1:0]))) begin
      align_fault_q <= 1'b1;
    end
  end
  assign fault = align_fault_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^{StartPC[1:0], RedirectPC[1:0]};
  assign fault = 1'b0;
`endif

  assign MemReq      = mem_req_q;
  assign MemAddr     = mem_addr_q;
  assign InstrValid  = (count_q != '0);
  assign Instruction = data_q[rd_ptr_q];
  assign InstrPC     = pc_q[rd_ptr_q];
  assign QueueCount  = count_q;
  assign AlignFault  = fault;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: variable-latency memory model, directed scenarios,
// randomized traffic, and a stream model (consecutive PCs from the last reset/redirect target).
module tb_ifetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [63:0] start_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  queue_count;
  logic        align_fault;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int n_acks   = 0;
  int n_deliv  = 0;
  int lat      = 1;
  int mem_cnt  = 0;
  logic spurious_ack = 1'b0;

  logic [95:0] exp_q[$];
  logic [63:0] model_pc;

  ifetch_prefetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .CLK(clk), .Reset(rst), .StartPC(start_pc), .Redirect(redirect),
    .RedirectPC(redirect_pc), .MemReq(mem_req), .MemAddr(mem_addr),
    .MemAck(mem_ack), .MemData(mem_data), .InstrValid(instr_valid),
    .Instruction(instruction), .InstrPC(instr_pc), .InstrReady(instr_ready),
    .QueueCount(queue_count), .AlignFault(align_fault), .DbgState(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory: acks after lat cycles of a held request, data is a function of the address
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spurious_ack) begin
        mem_ack  = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        mem_cnt  = 0;
      end else if (mem_req) begin
        if (mem_cnt >= lat - 1) begin
          mem_ack  = 1'b1;
          mem_data = word_of(mem_addr);
          mem_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          mem_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_pc, word_of(model_pc)});
      model_pc = model_pc + 64'd4;
    end
  endtask

  // scoreboard monitor: samples one time unit before each rising edge
  initial begin
    logic        prev_req, prev_ack, prev_rst;
    logic [63:0] prev_addr;
    logic [95:0] e;
    prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b1; prev_addr = '0;
    forever begin
      @(negedge clk);
      #4;
      if (prev_req && !prev_ack && !prev_rst) begin
        check("req_held", 64'(mem_req), 64'd1);
        check("addr_stable", mem_addr, prev_addr);
      end
      check("valid_vs_count", 64'(instr_valid), 64'(queue_count != 3'd0));
      check("count_bound", 64'(queue_count <= 3'd4), 64'd1);
      if (mem_req && mem_ack && !rst) n_acks++;
      if (rst) begin
        exp_q.delete();
        model_pc = {start_pc[63:2], 2'b00};
        refill();
      end else if (redirect) begin
        exp_q.delete();
        model_pc = {redirect_pc[63:2], 2'b00};
        refill();
      end else if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        check("deliver_pc", instr_pc, e[95:32]);
        check("deliver_word", 64'(instruction), 64'(e[31:0]));
        n_deliv++;
        refill();
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_rst = rst; prev_addr = mem_addr;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] pc, input int l);
    rst = 1'b1;
    start_pc = pc;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    while (mem_req !== lvl && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(mem_req), 64'(lvl));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int snap;
    int n;
    logic any_req;
    rst = 1'b1; start_pc = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_memreq", 64'(mem_req), 64'd0);
    check("rst_memaddr", mem_addr, 64'd0);
    check("rst_count", 64'(queue_count), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_fault", 64'(align_fault), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // 1: latency from release and one-per-cycle steady state
    instr_ready = 1'b1;
    do_reset(64'h0, 1);
    tick();
    check("lat_e1_req", 64'(mem_req), 64'd0);
    tick();
    check("lat_e2_req", 64'(mem_req), 64'd1);
    check("lat_e2_addr", mem_addr, 64'h0);
    tick();
    check("lat_e3_valid", 64'(instr_valid), 64'd1);
    check("lat_e3_pc", instr_pc, 64'h0);
    repeat (4) tick();
    snap = n_deliv;
    any_req = 1'b1;
    repeat (16) begin
      tick();
      any_req = any_req & mem_req & instr_valid;
    end
    check("steady_req_valid", 64'(any_req), 64'd1);
    check("steady_rate", 64'(n_deliv - snap), 64'd16);

    // 2: stalled decode fills exactly DEPTH entries, then resumes at 0x10
    instr_ready = 1'b0;
    do_reset(64'h0, 1);
    snap = n_acks;
    repeat (30) tick();
    check("fill_acks", 64'(n_acks - snap), 64'd4);
    check("fill_count", 64'(queue_count), 64'd4);
    check("fill_req", 64'(mem_req), 64'd0);
    check("fill_head", instr_pc, 64'h0);
    instr_ready = 1'b1;
    snap = n_deliv;
    wait_req(1'b1, "resume_req");
    check("resume_addr", mem_addr, 64'h10);
    repeat (10) tick();
    check("resume_deliv", 64'(n_deliv - snap >= 4), 64'd1);

    // 3: redirect during third wait cycle of a 5-cycle fetch
    do_reset(64'h0, 5);
    wait_req(1'b1, "t3_req");
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    check("t3_held_req", 64'(mem_req), 64'd1);
    check("t3_held_addr", mem_addr, 64'h0);
    wait_req(1'b0, "t3_drop");
    wait_req(1'b1, "t3_refetch");
    check("t3_addr", mem_addr, 64'h100);
    wait_valid("t3_valid");
    check("t3_first_pc", instr_pc, 64'h100);

    // 4: redirect coincident with MemAck and InstrReady at QueueCount=2
    instr_ready = 1'b0;
    do_reset(64'h0, 3);
    n = 0;
    @(negedge clk);
    while (!(mem_ack && queue_count == 3'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_sync", 64'(mem_ack && queue_count == 3'd2), 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h200;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    check("t4_count", 64'(queue_count), 64'd0);
    check("t4_valid", 64'(instr_valid), 64'd0);
    check("t4_req_drop", 64'(mem_req), 64'd0);
    wait_req(1'b1, "t4_refetch");
    check("t4_addr", mem_addr, 64'h200);

    // 5: reset with a request outstanding, then a stray ack while idle
    do_reset(64'h40, 4);
    wait_req(1'b1, "t5_req");
    tick();
    rst = 1'b1;
    start_pc = 64'h80;
    tick();
    check("t5_req_abort", 64'(mem_req), 64'd0);
    check("t5_count", 64'(queue_count), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    spurious_ack = 1'b1;
    @(negedge clk);
    spurious_ack = 1'b0;
    check("t5_stray_count", 64'(queue_count), 64'd0);
    wait_req(1'b1, "t5_restart");
    check("t5_addr", mem_addr, 64'h80);
    wait_valid("t5_valid");
    check("t5_first_pc", instr_pc, 64'h80);

    // 6: misaligned redirect target
    do_reset(64'h0, 1);
    repeat (10) tick();
    redirect = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect = 1'b0;
`ifdef IFQ_ALIGN_CHECK_EN
    check("t6_fault", 64'(align_fault), 64'd1);
    check("t6_valid", 64'(instr_valid), 64'd0);
    repeat (3) tick();
    any_req = 1'b0;
    repeat (12) begin
      tick();
      any_req = any_req | mem_req | instr_valid;
    end
    check("t6_quiet", 64'(any_req), 64'd0);
    do_reset(64'h2, 1);
    repeat (2) tick();
    check("t6_start_fault", 64'(align_fault), 64'd1);
    check("t6_start_noreq", 64'(mem_req), 64'd0);
`else
    check("t6_nofault", 64'(align_fault), 64'd0);
    wait_req(1'b1, "t6_refetch");
    check("t6_addr", mem_addr, 64'h100);
`endif

    // randomized traffic
    do_reset({$urandom, $urandom} & ~64'h3, $urandom_range(1, 4));
    repeat (2000) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        do_reset({$urandom, $urandom} & ~64'h3, $urandom_range(1, 4));
      end else if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
`ifdef IFQ_ALIGN_CHECK_EN
        redirect_pc = {$urandom, $urandom} & ~64'h3;
`else
        redirect_pc = {$urandom, $urandom};
`endif
      end
      tick();
      redirect = 1'b0;
    end
    instr_ready = 1'b1;
    repeat (20) tick();
    check("random_progress", 64'(n_deliv > 500), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
